fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for imem_ack before faulting.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_req  output  1  fetch request to instruction memory.
REQ-006 Port imem_addr  output  64  byte address of the requested instruction.
REQ-007 Port imem_ack  input  1  instruction memory response valid.
REQ-008 Port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 Port inst_valid  output  1  instruction and pc outputs are valid for decode.
REQ-010 Port instruction  output  32  latched instruction word.
REQ-011 Port opcode  output  11  instruction[31:21], feeding the control decoder.
REQ-012 Port pc  output  64  address of the latched instruction.
REQ-013 Port advance  input  1  downstream has finished the current instruction.
REQ-014 Port branch_taken  input  1  resolved branch outcome, sampled with advance.
REQ-015 Port branch_offset  input  64  sign-extended word offset, sampled with advance.
REQ-016 Port fetch_fault  output  1  sticky timeout indication.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD and FAULT.
REQ-018 IDLE SHALL last exactly one cycle, then go to FETCH; imem_ack in IDLE SHALL be ignored.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC register; both stay stable until ack.
REQ-020 On imem_ack in FETCH, the block SHALL latch imem_rdata into instruction and go to HOLD the next cycle.
REQ-021 inst_valid SHALL be 1 only in HOLD, and instruction, opcode and pc SHALL be held constant throughout HOLD.
REQ-022 In HOLD with advance=1, the PC SHALL become pc+4 if branch_taken=0 and pc+(branch_offset<<2) if branch_taken=1, and the state SHALL become FETCH.
REQ-023 PC arithmetic SHALL be 64-bit modulo 2^64; wrap-around is not an error.
REQ-024 advance and branch_taken SHALL be ignored outside HOLD.
REQ-025 In HOLD, imem_req SHALL be 0, and a stray imem_ack SHALL be ignored.
REQ-026 A wait counter SHALL clear on entry to FETCH and increment each FETCH cycle without ack.
REQ-027 If TIMEOUT cycles elapse in FETCH without ack, the FSM SHALL enter FAULT.
REQ-028 In FAULT, fetch_fault SHALL be 1, imem_req and inst_valid SHALL be 0, and the FSM SHALL remain there until reset.
REQ-029 An ack arriving in the same cycle the count reaches TIMEOUT SHALL be accepted; the ack takes priority.
REQ-030 Fetch latency SHALL be ack cycle + 1: inst_valid rises on the cycle after imem_ack.

Reset
REQ-031 reset SHALL take priority over all other inputs, including mid-fetch and in FAULT.
REQ-032 After reset: state=IDLE, PC=RESET_PC, imem_req=0, inst_valid=0, instruction=0, opcode=0, fetch_fault=0, wait counter=0.
REQ-033 An outstanding fetch aborted by reset SHALL be abandoned, and its late ack SHALL be ignored per REQ-018.

Structure
REQ-034 State encodings and the default RESET_PC SHALL live in the shared constants.vh include.
REQ-035 Next-PC selection (pc+4 versus branch target) SHALL be a separate combinational sub-module, next_pc.
REQ-036 Latched instruction, PC, state and wait counter SHALL be the only registers.

Verification
REQ-037 Basic fetch: reset, then ack with rdata=32'h8B020020 two cycles into FETCH -> imem_addr=0, then inst_valid=1, opcode=11'h458, pc=0.
REQ-038 Sequential step: HOLD at pc=0x10, advance=1, branch_taken=0 -> next imem_addr=0x14.
REQ-039 Backward branch: pc=0x20, advance=1, branch_taken=1, branch_offset=-2 -> imem_addr=0x18; at pc=0xFFFF_FFFF_FFFF_FFFC with offset +1, the address SHALL wrap to 0.
REQ-040 Timeout: TIMEOUT=4, never ack -> fetch_fault=1 after 4 FETCH cycles, imem_req=0; ack on the 4th cycle instead -> HOLD, no fault.
REQ-041 Reset mid-fetch: assert reset while imem_req=1, then ack in the first cycle after reset -> ack ignored, inst_valid=0, next fetch at RESET_PC.
REQ-042 Advance held outside HOLD: advance=1 continuously during FETCH -> PC unchanged until HOLD.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit.
// Holds the FSM state encodings and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [63:0] DEF_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection for the fetch unit.
// Picks sequential pc+4 or the word-offset branch target, modulo 2^64.
module fetch_unit_next_pc (
  input  logic [63:0] i_pc,
  input  logic        i_taken,
  input  logic [63:0] i_offset,
  output logic [63:0] o_next_pc
);

  logic [63:0] w_seq;
  logic [63:0] w_tgt;

  assign w_seq = i_pc + 64'd4;
  assign w_tgt = i_pc + (i_offset << 2);

  assign o_next_pc = i_taken ? w_tgt : w_seq;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD/FAULT sequencer with
// a bounded wait for imem_ack and a sticky timeout fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [10:0] opcode,
  output logic [63:0] pc,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [63:0] branch_offset,
  output logic        fetch_fault
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [63:0]  r_pc;
  logic [63:0]  w_pc_nxt;
  logic [31:0]  r_instr;
  logic [31:0]  w_instr_nxt;
  logic [CW-1:0] r_wait;
  logic [CW-1:0] w_wait_nxt;
  logic [CW-1:0] w_wait_inc;
  logic [63:0]  w_target;

  fetch_unit_next_pc u_next_pc (
    .i_pc      (r_pc),
    .i_taken   (branch_taken),
    .i_offset  (branch_offset),
    .o_next_pc (w_target)
  );

  assign w_wait_inc = r_wait + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_wait_nxt  = r_wait;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_wait_nxt  = '0;
      end
      S_FETCH: begin
        // ack wins even on the cycle the wait count would expire
        if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = S_HOLD;
        end else begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == CW'(TIMEOUT))
            w_state_nxt = S_FAULT;
        end
      end
      S_HOLD: begin
        if (advance) begin
          w_pc_nxt    = w_target;
          w_wait_nxt  = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign inst_valid  = (r_state == S_HOLD);
  assign fetch_fault = (r_state == S_FAULT);
  assign instruction = r_instr;
  assign opcode      = r_instr[31:21];
  assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (TIMEOUT=4, RESET_PC=0).
// Scenario tasks check outputs 1ns after each rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [10:0] opcode;
  logic [63:0] pc;
  logic        advance;
  logic        branch_taken;
  logic [63:0] branch_offset;
  logic        fetch_fault;

  int n_cmp;
  int n_err;

  fetch_unit #(
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .instruction   (instruction),
    .opcode        (opcode),
    .pc            (pc),
    .advance       (advance),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_now(input logic [31:0] d);
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic adv(input logic t, input logic [63:0] off);
    advance       = 1'b1;
    branch_taken  = t;
    branch_offset = off;
    tick();
    advance       = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 64'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req got %b exp 0", imem_req);
    end
    n_cmp++;
    if (inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flags got v=%b f=%b exp 0/0", inst_valid, fetch_fault);
    end
    n_cmp++;
    if (instruction !== 32'h0 || opcode !== 11'h0 || pc !== 64'h0) begin
      n_err++;
      $display("FAIL rst_regs got i=%h o=%h pc=%h exp zeros", instruction, opcode, pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL basic_req got r=%b a=%h exp 1/0", imem_req, imem_addr);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_wait got r=%b v=%b exp 1/0", imem_req, inst_valid);
    end
    ack_now(32'h8B02_0020);
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL basic_valid got v=%b r=%b exp 1/0", inst_valid, imem_req);
    end
    n_cmp++;
    if (opcode !== 11'h458 || instruction !== 32'h8B02_0020 || pc !== 64'h0) begin
      n_err++;
      $display("FAIL basic_data got o=%h i=%h pc=%h exp 458/8b020020/0", opcode, instruction, pc);
    end
  endtask

  task automatic test_seq_step();
    adv(1'b1, 64'd4);
    n_cmp++;
    if (imem_addr !== 64'h10 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump10 got a=%h r=%b v=%b exp 10/1/0", imem_addr, imem_req, inst_valid);
    end
    ack_now(32'h1111_0000);
    adv(1'b0, 64'h0);
    n_cmp++;
    if (imem_addr !== 64'h14) begin
      n_err++;
      $display("FAIL seq_step got %h exp 14", imem_addr);
    end
  endtask

  task automatic test_branch();
    ack_now(32'h2222_0000);
    adv(1'b1, 64'd3);
    n_cmp++;
    if (imem_addr !== 64'h20) begin
      n_err++;
      $display("FAIL br_fwd got %h exp 20", imem_addr);
    end
    ack_now(32'h3333_0000);
    n_cmp++;
    if (pc !== 64'h20 || instruction !== 32'h3333_0000) begin
      n_err++;
      $display("FAIL br_hold got pc=%h i=%h exp 20/33330000", pc, instruction);
    end
    adv(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    n_cmp++;
    if (imem_addr !== 64'h18) begin
      n_err++;
      $display("FAIL br_back got %h exp 18", imem_addr);
    end
    ack_now(32'h4444_0000);
    adv(1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
    n_cmp++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++;
      $display("FAIL br_top got %h exp fffffffffffffffc", imem_addr);
    end
    ack_now(32'h5555_0000);
    adv(1'b1, 64'd1);
    n_cmp++;
    if (imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL br_wrap got %h exp 0", imem_addr);
    end
  endtask

  task automatic test_advance_in_fetch();
    advance       = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 64'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (imem_addr !== 64'h0 || imem_req !== 1'b1) begin
        n_err++;
        $display("FAIL adv_fetch[%0d] got a=%h r=%b exp 0/1", i, imem_addr, imem_req);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h6666_0000;
    tick();
    imem_ack   = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b1 || pc !== 64'h0 || fetch_fault !== 1'b0) begin
      n_err++;
      $display("FAIL adv_hold got v=%b pc=%h f=%b exp 1/0/0", inst_valid, pc, fetch_fault);
    end
    tick();
    advance       = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 64'h0;
    n_cmp++;
    if (imem_addr !== 64'h14 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL adv_take got a=%h r=%b exp 14/1", imem_addr, imem_req);
    end
  endtask

  task automatic test_stray_ack_hold();
    ack_now(32'h7777_0001);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_ack   = 1'b0;
    n_cmp++;
    if (instruction !== 32'h7777_0001 || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ack got i=%h v=%b r=%b exp 77770001/1/0", instruction, inst_valid, imem_req);
    end
    n_cmp++;
    if (pc !== 64'h14 || opcode !== 11'h3BB) begin
      n_err++;
      $display("FAIL stray_pc got pc=%h o=%h exp 14/3bb", pc, opcode);
    end
  endtask

  task automatic test_timeout_edge();
    adv(1'b0, 64'h0);
    tick();
    tick();
    tick();
    ack_now(32'h8888_0000);
    n_cmp++;
    if (inst_valid !== 1'b1 || fetch_fault !== 1'b0 || pc !== 64'h18) begin
      n_err++;
      $display("FAIL to_edge got v=%b f=%b pc=%h exp 1/0/18", inst_valid, fetch_fault, pc);
    end
  endtask

  task automatic test_timeout();
    adv(1'b0, 64'h0);
    tick();
    tick();
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
      n_err++;
      $display("FAIL to_pre got r=%b f=%b exp 1/0", imem_req, fetch_fault);
    end
    tick();
    n_cmp++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL to_fault got f=%b r=%b v=%b exp 1/0/0", fetch_fault, imem_req, inst_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h9999_0000;
    advance    = 1'b1;
    tick();
    tick();
    imem_ack   = 1'b0;
    advance    = 1'b0;
    n_cmp++;
    if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 64'h1C) begin
      n_err++;
      $display("FAIL to_sticky got f=%b v=%b a=%h exp 1/0/1c", fetch_fault, inst_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (fetch_fault !== 1'b0 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL rst_fault got f=%b a=%h exp 0/0", fetch_fault, imem_addr);
    end
    tick();
    ack_now(32'hAAAA_0000);
    adv(1'b0, 64'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin
      n_err++;
      $display("FAIL mid_pre got r=%b a=%h exp 1/4", imem_req, imem_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBBBB_0000;
    tick();
    imem_ack   = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL mid_ack got v=%b r=%b a=%h exp 0/1/0", inst_valid, imem_req, imem_addr);
    end
    n_cmp++;
    if (instruction !== 32'h0) begin
      n_err++;
      $display("FAIL mid_instr got %h exp 0", instruction);
    end
    tick();
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after got v=%b r=%b exp 0/1", inst_valid, imem_req);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    advance       = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 64'h0;
    test_reset();
    test_basic_fetch();
    test_seq_step();
    test_branch();
    test_advance_in_fetch();
    test_stray_ack_hold();
    test_timeout_edge();
    test_timeout();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
